// File: rtl/qdr_pkg.sv
// rtl/qdr_pkg.sv - shared constants and FSM encoding for the QDR delay sequencer
package qdr_pkg;

    localparam int TAP_W = 5;
    localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;

    localparam logic BANK_IN  = 1'b0;
    localparam logic BANK_OUT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_SETTLE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/qdr_tap_shadow.sv
// rtl/qdr_tap_shadow.sv - saturating shadow tap counters with saturation flags and read mux
module qdr_tap_shadow
    import qdr_pkg::*;
#(
    parameter int N_IN  = 36,
    parameter int N_OUT = 37
) (
    input  logic                   dly_clk,
    input  logic                   rst,
    input  logic [N_IN+N_OUT-1:0]  tap_en,
    input  logic                   tap_dir,
    output logic [N_IN+N_OUT-1:0]  tap_sat,
    input  logic                   rd_bank,
    input  logic [5:0]             rd_bit,
    output logic [TAP_W-1:0]       rd_tap
);

    localparam int N_TOT = N_IN + N_OUT;

    // Input bank occupies [0, N_IN), output bank [N_IN, N_TOT).
    logic [TAP_W-1:0] tap_q [N_TOT];

    always_comb begin
        tap_sat = '0;
        for (int i = 0; i < N_TOT; i++) begin
            tap_sat[i] = tap_dir ? (tap_q[i] == TAP_MAX) : (tap_q[i] == '0);
        end
    end

    always_ff @(posedge dly_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TOT; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_TOT; i++) begin
                if (tap_en[i] && !tap_sat[i]) begin
                    tap_q[i] <= tap_dir ? tap_q[i] + 1'b1 : tap_q[i] - 1'b1;
                end
            end
        end
    end

    // Out-of-range selects match no entry and fall through to zero.
    always_comb begin
        rd_tap = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (rd_bank == BANK_IN && rd_bit == 6'(i)) begin
                rd_tap = tap_q[i];
            end
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (rd_bank == BANK_OUT && rd_bit == 6'(j)) begin
                rd_tap = tap_q[N_IN+j];
            end
        end
    end

endmodule

// File: rtl/qdr_dly_sequencer.sv
// rtl/qdr_dly_sequencer.sv - command-driven IODELAY tap stepper with settle spacing and shadow taps
module qdr_dly_sequencer
    import qdr_pkg::*;
#(
    parameter int N_IN   = 36,
    parameter int N_OUT  = 37,
    parameter int SETTLE = 4
) (
    input  logic              dly_clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_bank,
    input  logic              cmd_all,
    input  logic [5:0]        cmd_bit,
    input  logic              cmd_dir,
    input  logic [4:0]        cmd_steps,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sat,
    output logic [N_IN-1:0]   dly_en_i,
    output logic [N_OUT-1:0]  dly_en_o,
    output logic              dly_inc_dec,
    input  logic              rd_bank,
    input  logic [5:0]        rd_bit,
    output logic [TAP_W-1:0]  rd_tap
);

    localparam int N_TOT = N_IN + N_OUT;
    localparam int SCW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

    seq_state_t        state_q, state_d;
    logic              lat_bank;
    logic              lat_all;
    logic [5:0]        lat_bit;
    logic              lat_dir;
    logic [4:0]        step_q;
    logic [SCW-1:0]    settle_q;
    logic              err_q;
    logic              sat_q;

    logic              bad_bit;
    logic [N_TOT-1:0]  tgt;
    logic [N_TOT-1:0]  tap_sat;
    logic [N_TOT-1:0]  pulse_vec;
    logic              sat_hit;

    assign bad_bit = !lat_all &&
                     ((lat_bank == BANK_IN  && {1'b0, lat_bit} >= 7'(N_IN)) ||
                      (lat_bank == BANK_OUT && {1'b0, lat_bit} >= 7'(N_OUT)));

    always_comb begin
        tgt = '0;
        for (int i = 0; i < N_IN; i++) begin
            tgt[i] = (lat_bank == BANK_IN) && (lat_all || lat_bit == 6'(i));
        end
        for (int j = 0; j < N_OUT; j++) begin
            tgt[N_IN+j] = (lat_bank == BANK_OUT) && (lat_all || lat_bit == 6'(j));
        end
    end

    // Enables are decoded from the state register so an async reset kills them at once.
    assign pulse_vec = (state_q == ST_PULSE) ? (tgt & ~tap_sat) : '0;
    assign sat_hit   = (state_q == ST_PULSE) && |(tgt & tap_sat);

    assign dly_en_i    = pulse_vec[N_IN-1:0];
    assign dly_en_o    = pulse_vec[N_TOT-1:N_IN];
    assign dly_inc_dec = lat_dir;
    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_DONE) && err_q;
    assign sat         = sat_q;

    always_ff @(posedge dly_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
            ST_SETUP:  begin
                if (bad_bit || step_q == '0) state_d = ST_DONE;
                else                         state_d = ST_PULSE;
            end
            ST_PULSE:  state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_q == '0) state_d = (step_q != '0) ? ST_PULSE : ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge dly_clk or posedge rst) begin
        if (rst) begin
            lat_bank <= 1'b0;
            lat_all  <= 1'b0;
            lat_bit  <= '0;
            lat_dir  <= 1'b0;
            step_q   <= '0;
            settle_q <= '0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        lat_bank <= cmd_bank;
                        lat_all  <= cmd_all;
                        lat_bit  <= cmd_bit;
                        lat_dir  <= cmd_dir;
                        step_q   <= cmd_steps;
                        err_q    <= 1'b0;
                        sat_q    <= 1'b0;
                    end
                end
                ST_SETUP:  err_q <= bad_bit;
                ST_PULSE: begin
                    step_q   <= step_q - 1'b1;
                    settle_q <= SETTLE_LAST;
                    if (sat_hit) sat_q <= 1'b1;
                end
                ST_SETTLE: begin
                    if (settle_q != '0) settle_q <= settle_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    qdr_tap_shadow #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_shadow (
        .dly_clk (dly_clk),
        .rst     (rst),
        .tap_en  (pulse_vec),
        .tap_dir (lat_dir),
        .tap_sat (tap_sat),
        .rd_bank (rd_bank),
        .rd_bit  (rd_bit),
        .rd_tap  (rd_tap)
    );

endmodule

// File: tb/tb_qdr_dly_sequencer.sv
// tb/tb_qdr_dly_sequencer.sv - directed self-checking bench for qdr_dly_sequencer
module tb_qdr_dly_sequencer;

    localparam int N_IN   = 36;
    localparam int N_OUT  = 37;
    localparam int SETTLE = 4;

    logic              dly_clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_bank;
    logic              cmd_all;
    logic [5:0]        cmd_bit;
    logic              cmd_dir;
    logic [4:0]        cmd_steps;
    logic              busy;
    logic              done;
    logic              err;
    logic              sat;
    logic [N_IN-1:0]   dly_en_i;
    logic [N_OUT-1:0]  dly_en_o;
    logic              dly_inc_dec;
    logic              rd_bank;
    logic [5:0]        rd_bit;
    logic [4:0]        rd_tap;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #10 dly_clk = ~dly_clk;

    qdr_dly_sequencer #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .SETTLE (SETTLE)
    ) dut (
        .dly_clk     (dly_clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_bank    (cmd_bank),
        .cmd_all     (cmd_all),
        .cmd_bit     (cmd_bit),
        .cmd_dir     (cmd_dir),
        .cmd_steps   (cmd_steps),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .sat         (sat),
        .dly_en_i    (dly_en_i),
        .dly_en_o    (dly_en_o),
        .dly_inc_dec (dly_inc_dec),
        .rd_bank     (rd_bank),
        .rd_bit      (rd_bit),
        .rd_tap      (rd_tap)
    );

    // Returns at mid-cycle 1 (SETUP) of the issued command.
    task automatic send(input logic bank, input logic all, input logic [5:0] bit_idx,
                        input logic dir, input logic [4:0] steps);
        @(negedge dly_clk);
        cmd_bank  = bank;
        cmd_all   = all;
        cmd_bit   = bit_idx;
        cmd_dir   = dir;
        cmd_steps = steps;
        cmd_valid = 1'b1;
        @(negedge dly_clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic rd(input logic bank, input logic [5:0] bit_idx, output logic [4:0] v);
        rd_bank = bank;
        rd_bit  = bit_idx;
        #1;
        v = rd_tap;
    endtask

    task automatic run_wait(input logic bank, input logic all, input logic [5:0] bit_idx,
                            input logic dir, input logic [4:0] steps);
        bit got = 1'b0;
        send(bank, all, bit_idx, dir, steps);
        for (int c = 1; c <= 300 && !got; c++) begin
            if (c > 1) begin @(negedge dly_clk); #1; end
            if (done) got = 1'b1;
        end
        total_cnt++;
        if (!got) $display("FAIL run_wait_done: got no done, want done within 300 cycles");
        else pass_cnt++;
        @(negedge dly_clk); #1;
    endtask

    task automatic test_reset;
        logic [4:0] v;
        rst = 1'b1;
        repeat (2) @(negedge dly_clk);
        #1;
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else pass_cnt++;
        total_cnt++; if ({busy, done, err, sat} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy, done, err, sat}); else pass_cnt++;
        total_cnt++; if (dly_en_i !== '0 || dly_en_o !== '0) $display("FAIL reset_en: got %h/%h want 0/0", dly_en_i, dly_en_o); else pass_cnt++;
        total_cnt++; if (dly_inc_dec !== 1'b0) $display("FAIL reset_dir: got %b want 0", dly_inc_dec); else pass_cnt++;
        rd(1'b0, 6'd5, v);
        total_cnt++; if (v !== 5'd0) $display("FAIL reset_tap: got %0d want 0", v); else pass_cnt++;
        @(negedge dly_clk);
        rst = 1'b0;
        @(negedge dly_clk);
    endtask

    task automatic test_single_inc;
        logic [N_IN-1:0] exp_i;
        logic [4:0] v;
        send(1'b0, 1'b0, 6'd5, 1'b1, 5'd3);
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) begin @(negedge dly_clk); #1; end
            exp_i = (c == 2 || c == 7 || c == 12) ? (N_IN'(1) << 5) : '0;
            total_cnt++; if (dly_en_i !== exp_i) $display("FAIL inc_en_i c%0d: got %h want %h", c, dly_en_i, exp_i); else pass_cnt++;
            total_cnt++; if (dly_en_o !== '0) $display("FAIL inc_en_o c%0d: got %h want 0", c, dly_en_o); else pass_cnt++;
            total_cnt++; if (done !== (c == 17)) $display("FAIL inc_done c%0d: got %b want %b", c, done, c == 17); else pass_cnt++;
            total_cnt++; if (busy !== (c <= 17)) $display("FAIL inc_busy c%0d: got %b want %b", c, busy, c <= 17); else pass_cnt++;
            total_cnt++; if (dly_inc_dec !== 1'b1) $display("FAIL inc_dir c%0d: got %b want 1", c, dly_inc_dec); else pass_cnt++;
        end
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL inc_ready_after: got %b want 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (sat !== 1'b0) $display("FAIL inc_sat: got %b want 0", sat); else pass_cnt++;
        rd(1'b0, 6'd5, v);
        total_cnt++; if (v !== 5'd3) $display("FAIL inc_tap: got %0d want 3", v); else pass_cnt++;
    endtask

    task automatic test_sat_inc;
        logic [4:0] v;
        run_wait(1'b1, 1'b0, 6'd36, 1'b1, 5'd31);
        total_cnt++; if (sat !== 1'b0) $display("FAIL fill_sat: got %b want 0", sat); else pass_cnt++;
        rd(1'b1, 6'd36, v);
        total_cnt++; if (v !== 5'd31) $display("FAIL fill_tap: got %0d want 31", v); else pass_cnt++;
        send(1'b1, 1'b0, 6'd36, 1'b1, 5'd2);
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) begin @(negedge dly_clk); #1; end
            total_cnt++; if (dly_en_o !== '0 || dly_en_i !== '0) $display("FAIL satinc_en c%0d: got %h/%h want 0/0", c, dly_en_i, dly_en_o); else pass_cnt++;
            total_cnt++; if (done !== (c == 12)) $display("FAIL satinc_done c%0d: got %b want %b", c, done, c == 12); else pass_cnt++;
        end
        total_cnt++; if (sat !== 1'b1) $display("FAIL satinc_sat: got %b want 1", sat); else pass_cnt++;
        @(negedge dly_clk);
        rd(1'b1, 6'd36, v);
        total_cnt++; if (v !== 5'd31) $display("FAIL satinc_tap: got %0d want 31", v); else pass_cnt++;
        rd(1'b1, 6'd37, v);
        total_cnt++; if (v !== 5'd0) $display("FAIL rd_oob_out: got %0d want 0", v); else pass_cnt++;
        rd(1'b0, 6'd36, v);
        total_cnt++; if (v !== 5'd0) $display("FAIL rd_oob_in: got %0d want 0", v); else pass_cnt++;
    endtask

    task automatic test_all_dec;
        logic [N_OUT-1:0] exp_o;
        logic [4:0] v;
        run_wait(1'b1, 1'b1, 6'd0, 1'b1, 5'd2);
        total_cnt++; if (sat !== 1'b1) $display("FAIL allinc_sat: got %b want 1", sat); else pass_cnt++;
        rd(1'b1, 6'd36, v);
        total_cnt++; if (v !== 5'd31) $display("FAIL allinc_b36: got %0d want 31", v); else pass_cnt++;
        rd(1'b1, 6'd5, v);
        total_cnt++; if (v !== 5'd2) $display("FAIL allinc_b5: got %0d want 2", v); else pass_cnt++;
        rd(1'b0, 6'd5, v);
        total_cnt++; if (v !== 5'd3) $display("FAIL allinc_inbank: got %0d want 3", v); else pass_cnt++;
        run_wait(1'b1, 1'b0, 6'd0, 1'b0, 5'd2);
        exp_o = '1;
        exp_o[0] = 1'b0;
        send(1'b1, 1'b1, 6'd0, 1'b0, 5'd1);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(negedge dly_clk); #1; end
            total_cnt++; if (dly_en_o !== ((c == 2) ? exp_o : '0)) $display("FAIL alldec_en_o c%0d: got %h want %h", c, dly_en_o, (c == 2) ? exp_o : '0); else pass_cnt++;
            total_cnt++; if (dly_en_i !== '0) $display("FAIL alldec_en_i c%0d: got %h want 0", c, dly_en_i); else pass_cnt++;
            total_cnt++; if (done !== (c == 7)) $display("FAIL alldec_done c%0d: got %b want %b", c, done, c == 7); else pass_cnt++;
            total_cnt++; if (dly_inc_dec !== 1'b0) $display("FAIL alldec_dir c%0d: got %b want 0", c, dly_inc_dec); else pass_cnt++;
        end
        total_cnt++; if (sat !== 1'b1) $display("FAIL alldec_sat: got %b want 1", sat); else pass_cnt++;
        @(negedge dly_clk);
        rd(1'b1, 6'd0, v);
        total_cnt++; if (v !== 5'd0) $display("FAIL alldec_b0: got %0d want 0", v); else pass_cnt++;
        rd(1'b1, 6'd1, v);
        total_cnt++; if (v !== 5'd1) $display("FAIL alldec_b1: got %0d want 1", v); else pass_cnt++;
        rd(1'b1, 6'd36, v);
        total_cnt++; if (v !== 5'd30) $display("FAIL alldec_b36: got %0d want 30", v); else pass_cnt++;
    endtask

    task automatic test_bad_bit;
        send(1'b0, 1'b0, 6'd36, 1'b1, 5'd7);
        total_cnt++; if (sat !== 1'b0) $display("FAIL bad_sat_clear: got %b want 0", sat); else pass_cnt++;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin @(negedge dly_clk); #1; end
            total_cnt++; if (dly_en_i !== '0 || dly_en_o !== '0) $display("FAIL bad_en c%0d: got %h/%h want 0/0", c, dly_en_i, dly_en_o); else pass_cnt++;
            total_cnt++; if (done !== (c == 2)) $display("FAIL bad_done c%0d: got %b want %b", c, done, c == 2); else pass_cnt++;
            total_cnt++; if (err !== (c == 2)) $display("FAIL bad_err c%0d: got %b want %b", c, err, c == 2); else pass_cnt++;
            total_cnt++; if (cmd_ready !== (c == 3)) $display("FAIL bad_ready c%0d: got %b want %b", c, cmd_ready, c == 3); else pass_cnt++;
        end
    endtask

    task automatic test_zero_steps;
        logic [4:0] v;
        send(1'b0, 1'b0, 6'd0, 1'b1, 5'd0);
        total_cnt++; if (busy !== 1'b1) $display("FAIL zero_busy_c1: got %b want 1", busy); else pass_cnt++;
        cmd_steps = 5'd5;
        cmd_valid = 1'b1;
        @(negedge dly_clk); #1;
        total_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL zero_done_c2: got done=%b err=%b want 1/0", done, err); else pass_cnt++;
        cmd_valid = 1'b0;
        for (int c = 3; c <= 12; c++) begin
            @(negedge dly_clk); #1;
            total_cnt++; if (busy !== 1'b0) $display("FAIL zero_dropped c%0d: got busy=%b want 0", c, busy); else pass_cnt++;
            total_cnt++; if (dly_en_i !== '0) $display("FAIL zero_en c%0d: got %h want 0", c, dly_en_i); else pass_cnt++;
        end
        rd(1'b0, 6'd0, v);
        total_cnt++; if (v !== 5'd0) $display("FAIL zero_tap: got %0d want 0", v); else pass_cnt++;
    endtask

    task automatic test_reset_abort;
        logic [4:0] v;
        int bad;
        send(1'b0, 1'b0, 6'd10, 1'b1, 5'd5);
        for (int c = 2; c <= 7; c++) begin
            @(negedge dly_clk); #1;
        end
        total_cnt++; if (dly_en_i !== (N_IN'(1) << 10)) $display("FAIL abort_pulse_c7: got %h want %h", dly_en_i, N_IN'(1) << 10); else pass_cnt++;
        @(negedge dly_clk);
        rst = 1'b1;
        #1;
        total_cnt++; if (dly_en_i !== '0 || dly_en_o !== '0) $display("FAIL abort_en: got %h/%h want 0/0", dly_en_i, dly_en_o); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags: got busy=%b done=%b want 0/0", busy, done); else pass_cnt++;
        rd(1'b0, 6'd10, v);
        total_cnt++; if (v !== 5'd0) $display("FAIL abort_tap10: got %0d want 0", v); else pass_cnt++;
        rd(1'b1, 6'd36, v);
        total_cnt++; if (v !== 5'd0) $display("FAIL abort_tap_o36: got %0d want 0", v); else pass_cnt++;
        @(negedge dly_clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge dly_clk); #1;
            if (done !== 1'b0 || dly_en_i !== '0 || dly_en_o !== '0 || cmd_ready !== 1'b1) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL abort_after: got %0d bad cycles want 0", bad); else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_bank  = 1'b0;
        cmd_all   = 1'b0;
        cmd_bit   = '0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        rd_bank   = 1'b0;
        rd_bit    = '0;
        test_reset;
        test_single_inc;
        test_sat_inc;
        test_all_dec;
        test_bad_bit;
        test_zero_steps;
        test_reset_abort;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
